// File: rtl/lstm_cell_state_buf.sv
// ----------------------------------------------------------------------------
// lstm_cell_state_buf
//
// Cell-state store for the LSTM compute datapath. It supplies c(t-1) one cell
// per request on the read side and absorbs c(t) written back on the write
// side. Both sides walk the cells in order 0..NUM_CELLS-1 within a timestep.
// State is kept across timesteps until clear_state invalidates every cell.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   step_start     pulse, begin a timestep (IDLE only)
//   clear_state    pulse, invalidate all cells (IDLE only)
//   rd_req         request c(t-1) of the next cell in order
//   cram_data_out  c(t-1) word, registered, one cycle after rd_req
//   cram_valid_out cram_data_out valid this cycle
//   wb_valid       c(t) of the next cell in order is presented
//   wb_data        c(t) word
//   busy           a timestep is in progress
//   step_done      one-cycle pulse after the last write-back of a step
//   outstanding    reads issued minus write-backs received this step
//   err            sticky protocol error, cleared by an accepted step_start
// ----------------------------------------------------------------------------
module lstm_cell_state_buf #(
    parameter  int DATA_BITS = 16,
    parameter  int NUM_CELLS = 64,
    localparam int CW        = $clog2(NUM_CELLS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 step_start,
    input  logic                 clear_state,
    input  logic                 rd_req,
    output logic [DATA_BITS-1:0] cram_data_out,
    output logic                 cram_valid_out,
    input  logic                 wb_valid,
    input  logic [DATA_BITS-1:0] wb_data,
    output logic                 busy,
    output logic                 step_done,
    output logic [CW-1:0]        outstanding,
    output logic                 err
);

    localparam int            IW   = $clog2(NUM_CELLS);
    localparam logic [CW-1:0] FULL = CW'(NUM_CELLS);
    localparam logic [CW-1:0] LAST = CW'(NUM_CELLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                 state;
    logic [CW-1:0]          rd_cnt;
    logic [CW-1:0]          wr_cnt;
    logic [NUM_CELLS-1:0]   cell_valid;
    logic [DATA_BITS-1:0]   mem [NUM_CELLS];

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic          rd_ok;
    logic          wb_ok;
    logic          step_ok;
    logic          clr_ok;
    logic          finish;
    logic          err_set;

    assign rd_idx = rd_cnt[IW-1:0];
    assign wr_idx = wr_cnt[IW-1:0];

    // RUN lingers one cycle with rd_cnt == FULL so that a write-back landing
    // in that cycle can close the step directly from RUN. Reads are refused
    // in that cycle just as they are in DRAIN.
    assign rd_ok   = rd_req && (state == RUN) && (rd_cnt != FULL);
    // A write may never overtake the reads: the cell must have been read first.
    assign wb_ok   = wb_valid && (state != IDLE) && (wr_cnt != rd_cnt);
    assign step_ok = step_start && (state == IDLE);
    assign clr_ok  = clear_state && (state == IDLE);
    assign finish  = wb_ok && (wr_cnt == LAST);

    assign err_set = (rd_req && !rd_ok)
                   | (wb_valid && !wb_ok)
                   | ((step_start || clear_state) && (state != IDLE));

    assign busy        = (state != IDLE);
    assign outstanding = rd_cnt - wr_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; a read and a write of the same cell in one
    // cycle therefore returns the old word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rd_cnt         <= '0;
            wr_cnt         <= '0;
            cell_valid     <= '0;
            cram_data_out  <= '0;
            cram_valid_out <= 1'b0;
            step_done      <= 1'b0;
            err            <= 1'b0;
        end else begin
            cram_valid_out <= rd_ok;
            step_done      <= 1'b0;
            err            <= (step_ok ? 1'b0 : err) | err_set;

            if (rd_ok) begin
                cram_data_out <= cell_valid[rd_idx] ? mem[rd_idx] : '0;
                rd_cnt        <= rd_cnt + CW'(1);
            end

            if (wb_ok) begin
                cell_valid[wr_idx] <= 1'b1;
                wr_cnt             <= wr_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    // Clear lands at this edge, so reads of the new step see 0.
                    if (clr_ok) cell_valid <= '0;
                    if (step_ok) begin
                        state  <= RUN;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state     <= IDLE;
                        step_done <= 1'b1;
                    end else if (rd_cnt == FULL) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (finish) begin
                        state     <= IDLE;
                        step_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the data array has no reset; the per-cell valid bits (which are
    // reset) decide whether a stored word or zero is returned.
    always_ff @(posedge clock) begin
        if (wb_ok) mem[wr_idx] <= wb_data;
    end

endmodule
